// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes, FSM encoding and access decode helpers for dmem_resp
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  // f3[1:0] selects size for both signed and unsigned loads
  function automatic logic acc_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    return (we ? (f3 > F3_W) : (f3 == 3'd3 || f3 > F3_HU)) ||
           (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a != 2'd0);
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == 2'd0 ? 4'b0001 << a : f3[1:0] == 2'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 synchronous RAM, byte-enable write, registered read
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    if (en_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: handshaked load/store responder with wait states over dmem_array
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WC_M1 = WAIT_CYCLES > 0 ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          we_q, err_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic          idle, commit, a_we, a_err;
  logic [AW+1:0] a_addr;
  logic [31:0]   a_wdata, rd, ext;
  logic [2:0]    a_f3;
  logic [7:0]    byt;
  logic [15:0]   half;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && req_valid) begin
      state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
      cnt_d   = WC_M1;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 3'd0 ? RESP : WAIT;
      cnt_d   = cnt_q == 3'd0 ? 3'd0 : cnt_q - 3'd1;
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    req_ready = state_q == IDLE;
    rsp_valid = state_q == RESP;
    rsp_err   = rsp_valid & err_q;
    rsp_rdata = (rsp_valid && !err_q && !we_q) ? ext : 32'd0;
  end

  // In IDLE the live request feeds the array so zero-wait commits on the accept edge
  assign idle    = state_q == IDLE;
  assign commit  = state_d == RESP && state_q != RESP;
  assign a_we    = idle ? req_we : we_q;
  assign a_addr  = idle ? req_addr[AW+1:0] : addr_q;
  assign a_wdata = idle ? req_wdata : wdata_q;
  assign a_f3    = idle ? req_funct3 : f3_q;
  assign a_err   = acc_err(a_we, a_f3, a_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (idle && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
      end
      if (commit) err_q <= a_err;
    end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk    (clk),
    .en_i   (commit),
    .be_i   ((commit && a_we && !a_err) ? byte_en(a_f3, a_addr[1:0]) : 4'b0000),
    .addr_i (a_addr[AW+1:2]),
    .wdata_i(a_f3[1:0] == 2'd0 ? {4{a_wdata[7:0]}} : a_f3[1:0] == 2'd1 ? {2{a_wdata[15:0]}} : a_wdata),
    .rdata_o(rd)
  );

  assign byt  = rd[{addr_q[1:0], 3'b000} +: 8];
  assign half = addr_q[1] ? rd[31:16] : rd[15:0];
  assign ext  = f3_q == F3_B  ? {{24{byt[7]}}, byt} :
                f3_q == F3_BU ? {24'd0, byt} :
                f3_q == F3_H  ? {{16{half[15]}}, half} :
                f3_q == F3_HU ? {16'd0, half} : rd;
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed checks of dmem_resp with WAIT_CYCLES=1 and a zero-wait instance
module tb_dmem_resp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_funct3;
  logic        zv, zrdy, zwe, zrv, zerr;
  logic [31:0] zaddr, zwdata, zrdata;
  logic [2:0]  zf3;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .req_valid(zv), .req_ready(zrdy), .req_we(zwe),
    .req_addr(zaddr), .req_wdata(zwdata), .req_funct3(zf3), .rsp_valid(zrv),
    .rsp_ready(1'b1), .rsp_rdata(zrdata), .rsp_err(zerr));

  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                      output logic [31:0] rd, output logic e, output int lat);
    req_we = we; req_addr = a; req_wdata = d; req_funct3 = f; req_valid = 1'b1;
    lat = 0;
    while (!req_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    @(posedge clk); #1; req_valid = 1'b0; lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata; e = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic xact_z(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                        output logic [31:0] rd, output logic e, output int lat);
    zwe = we; zaddr = a; zwdata = d; zf3 = f; zv = 1'b1;
    @(posedge clk); #1; zv = 1'b0; lat = 1;
    while (!zrv && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = zrdata; e = zerr;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    n_chk++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    n_chk++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", rsp_err); end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, rd, e, lat);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", lat); end
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL sw_err got %0b want 0", e); end
    n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL sw_rdata got %h want 0", rd); end
    xact(1'b0, 32'h10, 32'h0, 3'd2, rd, e, lat);
    n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL lw_latency got %0d want 2", lat); end
  endtask

  task automatic test_byte_half;
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 32'h11, 32'h00000080, 3'd0, rd, e, lat);
    xact(1'b0, 32'h11, 32'h0, 3'd0, rd, e, lat);
    n_chk++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb got %h want ffffff80", rd); end
    xact(1'b0, 32'h11, 32'h0, 3'd4, rd, e, lat);
    n_chk++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu got %h want 00000080", rd); end
    xact(1'b0, 32'h10, 32'h0, 3'd2, rd, e, lat);
    n_chk++; if (rd !== 32'hDEAD80EF) begin n_fail++; $display("FAIL lw_after_sb got %h want dead80ef", rd); end
    xact(1'b1, 32'h12, 32'h00001234, 3'd1, rd, e, lat);
    xact(1'b0, 32'h10, 32'h0, 3'd2, rd, e, lat);
    n_chk++; if (rd !== 32'h123480EF) begin n_fail++; $display("FAIL lw_after_sh got %h want 123480ef", rd); end
    xact(1'b0, 32'h10, 32'h0, 3'd1, rd, e, lat);
    n_chk++; if (rd !== 32'hFFFF80EF) begin n_fail++; $display("FAIL lh_low got %h want ffff80ef", rd); end
    xact(1'b0, 32'h10, 32'h0, 3'd5, rd, e, lat);
    n_chk++; if (rd !== 32'h000080EF) begin n_fail++; $display("FAIL lhu_low got %h want 000080ef", rd); end
    xact(1'b0, 32'h13, 32'h0, 3'd0, rd, e, lat);
    n_chk++; if (rd !== 32'h00000012) begin n_fail++; $display("FAIL lb_lane3 got %h want 00000012", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic e; int lat;
    xact(1'b0, 32'h13, 32'h0, 3'd1, rd, e, lat);
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL lh_misaligned_err got %0b want 1", e); end
    n_chk++; if (rd !== 32'd0) begin n_fail++; $display("FAIL lh_misaligned_rdata got %h want 0", rd); end
    xact(1'b1, 32'h12, 32'h55555555, 3'd2, rd, e, lat);
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL sw_misaligned_err got %0b want 1", e); end
    xact(1'b0, 32'h10, 32'h0, 3'd2, rd, e, lat);
    n_chk++; if (rd !== 32'h123480EF || e !== 1'b0) begin n_fail++; $display("FAIL sw_misaligned_nowrite got %h/%0b want 123480ef/0", rd, e); end
    xact(1'b0, 32'h10, 32'h0, 3'd3, rd, e, lat);
    n_chk++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL load_f3_3 got %h/%0b want 0/1", rd, e); end
    xact(1'b1, 32'h10, 32'h0, 3'd4, rd, e, lat);
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL store_f3_4 got %0b want 1", e); end
    xact(1'b0, 32'h10, 32'h0, 3'd2, rd, e, lat);
    n_chk++; if (rd !== 32'h123480EF) begin n_fail++; $display("FAIL store_f3_4_nowrite got %h want 123480ef", rd); end
    xact(1'b0, 32'h11, 32'h0, 3'd2, rd, e, lat);
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL lw_misaligned got %0b want 1", e); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic e; int lat;
    rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'd2; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0; lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h11111111; req_funct3 = 3'd2; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h123480EF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%0b d=%h e=%0b rr=%0b want 1/123480ef/0/0", i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%0b rr=%0b want 0/1", rsp_valid, req_ready); end
    @(posedge clk); #1; req_valid = 1'b0;
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept got rr=%0b want 0", req_ready); end
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_chk++; if (lat != 2 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_store_rsp got lat=%0d e=%0b want 2/0", lat, rsp_err); end
    @(posedge clk); #1;
    xact(1'b0, 32'h20, 32'h0, 3'd2, rd, e, lat);
    n_chk++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL bp_store_data got %h want 11111111", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic e; int lat;
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'd2; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_wait got rr=%0b want 0", req_ready); end
    rst_n = 1'b0; #2;
    n_chk++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs got rr=%0b v=%0b d=%h e=%0b want 1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_reset got v=%0b rr=%0b want 0/1", rsp_valid, req_ready); end
    xact(1'b0, 32'h10, 32'h0, 3'd2, rd, e, lat);
    n_chk++; if (rd !== 32'h123480EF) begin n_fail++; $display("FAIL mid_no_commit got %h want 123480ef", rd); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 32'h1000, 32'hA5A5A5A5, 3'd2, rd, e, lat);
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL wrap_store_err got %0b want 0", e); end
    xact(1'b0, 32'h0, 32'h0, 3'd2, rd, e, lat);
    n_chk++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wrap_load got %h want a5a5a5a5", rd); end
  endtask

  task automatic test_zero_wait;
    logic [31:0] rd; logic e; int lat;
    xact_z(1'b1, 32'h8, 32'h77665544, 3'd2, rd, e, lat);
    n_chk++; if (lat != 1 || e !== 1'b0) begin n_fail++; $display("FAIL zw_store got lat=%0d e=%0b want 1/0", lat, e); end
    xact_z(1'b0, 32'h8, 32'h0, 3'd2, rd, e, lat);
    n_chk++; if (lat != 1) begin n_fail++; $display("FAIL zw_latency got %0d want 1", lat); end
    n_chk++; if (rd !== 32'h77665544) begin n_fail++; $display("FAIL zw_load got %h want 77665544", rd); end
    xact_z(1'b0, 32'hA, 32'h0, 3'd1, rd, e, lat);
    n_chk++; if (rd !== 32'h00007766) begin n_fail++; $display("FAIL zw_lh got %h want 00007766", rd); end
  endtask

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
    rsp_ready = 1'b1; zv = 1'b0; zwe = 1'b0; zaddr = 32'd0; zwdata = 32'd0; zf3 = 3'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_word;
    test_byte_half;
    test_errors;
    test_backpressure;
    test_reset_mid;
    test_wrap;
    test_zero_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the ECNURVCORE data path: the slave end of the load/store address/data interface driven by the execute stage. It accepts one load or store request per handshake. Requests carry the effective address, store data and funct3. It inserts a configurable number of wait states, performs byte/half/word access with byte enables, and returns sign- or zero-extended load data or an error flag on a response handshake. It replaces the combinational data memory so the core can be moved to a multi-cycle or pipelined organisation.

## Interface
- DEPTH_WORDS, 1024: memory size in 32-bit words; power of two, AW = log2(DEPTH_WORDS).
- WAIT_CYCLES, 1: wait states between accept and response; legal range 0..7.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (addr_mem from execute).
- req_wdata  in  32  store data; the low byte or low half is used for SB/SH.
- req_funct3  in  3  RV32I load/store funct3.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access or illegal funct3.

## Operation
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata/funct3. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT: counter loads WAIT_CYCLES-1 and decrements each cycle. Go to RESP at 0.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- Word index = addr[AW+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH_WORDS*4. Wrap is not an error.
- Byte lane select uses addr[1:0].
- Stores:
  - SB (0) writes one lane.
  - SH (1) writes lanes {addr[1],0}+1..0.
  - SW (2) writes all four lanes.
  - Other lanes are unchanged.
- Loads:
  - LB (0) / LH (1) sign-extend.
  - LBU (4) / LHU (5) zero-extend.
  - LW (2) returns the full word.
- Errors set rsp_err=1 and rsp_rdata=0, with no memory write:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - load funct3 ∈ {3,6,7};
  - store funct3 ∈ {3..7}.
- Commit point: the array read or write happens on the clock edge that enters RESP. The response data is registered on that same edge.
- rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
- Memory contents are not reset. Only the FSM, counter, latched request and outputs are reset.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Latency: a request accepted in cycle T gives rsp_valid=1 in cycle T+1+WAIT_CYCLES.
- Throughput: one request per 2+WAIT_CYCLES cycles when rsp_ready is tied high. The response cycle and the next accept do not overlap.
- Handshake:
  - A transfer occurs when valid&ready are both high on a rising edge.
  - req_valid seen while req_ready=0 is ignored; the requester must hold it.
  - rsp_valid never drops without rsp_ready.
- Reset mid-operation:
  - Asserting rst_n=0 in WAIT aborts the request and the store is not committed.
  - Asserting it in RESP drops the pending response; a store already committed stays written.
- With WAIT_CYCLES=0, the commit occurs on the accept edge itself.

## Structure
- Package dmem_pkg holds:
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
- Sub-module dmem_array: synchronous DEPTH_WORDS×32 array with a 4-bit byte-enable write and a registered read port. It is instantiated once.
- The top level contains the FSM, counter, request latch, lane alignment/extension and error decode.

## Test plan
- WAIT_CYCLES=1; SW 0xDEADBEEF @0x10 accepted at T → rsp_valid at T+2, err=0. Then LW @0x10 → rdata 0xDEADBEEF.
- SB wdata 0x00000080 @0x11 → LB @0x11 returns 0xFFFFFF80, LBU returns 0x00000080, LW @0x10 returns 0xDEAD80EF. SH 0x1234 @0x12 → LW returns 0x123480EF.
- Misaligned accesses:
  - LH @0x13 → err=1, rdata=0.
  - SW 0x55555555 @0x12 → err=1, and LW @0x10 is unchanged.
  - Load funct3=3 → err=1.
- Backpressure: rsp_ready low 5 cycles → rsp_valid/rdata/err stable, req_ready=0, and a new req_valid is not accepted until the cycle after rsp_ready.
- Reset: SW 0x0 @0x10 with rst_n pulsed low during WAIT → all outputs at reset values, and a later LW @0x10 still returns the old data.
- Wrap: DEPTH_WORDS=1024, SW 0xA5A5A5A5 @0x1000 → LW @0x0 returns 0xA5A5A5A5. With WAIT_CYCLES=0, the response arrives at T+1.
